// File: rtl/jtag_target_conditioner.sv
// Conditions target-side JTAG signals for the FT2232: synchronises presence, nSRST sense and RTCK,
// debounces/filters them, stretches FT-requested nSRST drives and flags target-originated resets.
module jtag_target_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned GLITCH_CYCLES   = 4,
    parameter int unsigned SRST_MIN_CYCLES = 256
) (
    input  logic CLK,
    input  logic nRST,
    input  logic TARGET_PRESENT,
    input  logic nSRST_SENSE,
    input  logic RTCK,
    input  logic FT_nSRST_OE,
    input  logic FT_nSRST_OUT,
    input  logic EVENT_CLR,
    output logic FT_TARGET_PRESENT,
    output logic FT_nSRST_IN,
    output logic FT_RTCK,
    output logic nSRST_OE,
    output logic nSRST_OUT,
    output logic SRST_EVENT
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GL_W   = $clog2(GLITCH_CYCLES + 1);
    localparam int unsigned ST_W   = $clog2(SRST_MIN_CYCLES + 1);
    localparam int unsigned SYNC_W = 5;

    // Synchroniser bit map: {ft_out, ft_oe, rtck, sense, present}; idle levels match the reset outputs
    localparam logic [SYNC_W-1:0] SYNC_IDLE = 5'b11010;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        QUAL_IN  = 2'd1,
        PRESENT  = 2'd2,
        QUAL_OUT = 2'd3
    } pres_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } srst_state_t;

    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0]                  sync_raw;
    logic                               present_s;
    logic                               sense_s;
    logic                               oe_s;
    logic                               out_s;

    pres_state_t       pres_q,   pres_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DB_W-1:0]   db_inc;
    logic              db_done;
    logic              pres_out_q, pres_out_d;

    logic [GL_W-1:0]   gl_cnt_q, gl_cnt_d;
    logic              filt_q,   filt_d;

    srst_state_t       st_q,     st_d;
    logic [ST_W-1:0]   st_cnt_q, st_cnt_d;
    logic [ST_W-1:0]   st_inc;
    logic              st_done;
    logic              req_low;
    logic              oe_q,     oe_d;
    logic              out_q,    out_d;

    logic              event_q,  event_d;

    assign sync_raw  = {FT_nSRST_OUT, FT_nSRST_OE, RTCK, nSRST_SENSE, TARGET_PRESENT};
    assign present_s = sync_q[SYNC_STAGES-1][0];
    assign sense_s   = sync_q[SYNC_STAGES-1][1];
    assign oe_s      = sync_q[SYNC_STAGES-1][3];
    assign out_s     = sync_q[SYNC_STAGES-1][4];

    assign FT_TARGET_PRESENT = pres_out_q;
    assign FT_nSRST_IN       = filt_q;
    assign FT_RTCK           = sync_q[SYNC_STAGES-1][2];
    assign nSRST_OE          = oe_q;
    assign nSRST_OUT         = out_q;
    assign SRST_EVENT        = event_q;

    // Input synchronisers, newest sample in stage 0
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= {SYNC_STAGES{SYNC_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sync_raw};
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pres_q     <= ABSENT;
            db_cnt_q   <= '0;
            pres_out_q <= 1'b0;
            gl_cnt_q   <= '0;
            filt_q     <= 1'b1;
            st_q       <= IDLE;
            st_cnt_q   <= '0;
            oe_q       <= 1'b1;
            out_q      <= 1'b1;
            event_q    <= 1'b0;
        end else begin
            pres_q     <= pres_d;
            db_cnt_q   <= db_cnt_d;
            pres_out_q <= pres_out_d;
            gl_cnt_q   <= gl_cnt_d;
            filt_q     <= filt_d;
            st_q       <= st_d;
            st_cnt_q   <= st_cnt_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            event_q    <= event_d;
        end
    end

    // Saturating debounce count; done means this sample completes the qualification run
    assign db_inc  = (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) ? db_cnt_q : db_cnt_q + DB_W'(1);
    assign db_done = (db_cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1));

    // Presence debounce FSM
    always_comb begin
        pres_d   = pres_q;
        db_cnt_d = db_cnt_q;
        unique case (pres_q)
            ABSENT: begin
                if (present_s) begin
                    if (db_done) begin
                        pres_d   = PRESENT;
                        db_cnt_d = '0;
                    end else begin
                        pres_d   = QUAL_IN;
                        db_cnt_d = db_inc;
                    end
                end
            end
            QUAL_IN: begin
                if (!present_s) begin
                    pres_d   = ABSENT;
                    db_cnt_d = '0;
                end else if (db_done) begin
                    pres_d   = PRESENT;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            PRESENT: begin
                if (!present_s) begin
                    if (db_done) begin
                        pres_d   = ABSENT;
                        db_cnt_d = '0;
                    end else begin
                        pres_d   = QUAL_OUT;
                        db_cnt_d = db_inc;
                    end
                end
            end
            QUAL_OUT: begin
                if (present_s) begin
                    pres_d   = PRESENT;
                    db_cnt_d = '0;
                end else if (db_done) begin
                    pres_d   = ABSENT;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            default: begin
                pres_d   = ABSENT;
                db_cnt_d = '0;
            end
        endcase
        pres_out_d = (pres_d == PRESENT) || (pres_d == QUAL_OUT);
    end

    // nSRST sense glitch filter: a run of disagreeing samples flips the output, any agreeing sample restarts it
    always_comb begin
        filt_d   = filt_q;
        gl_cnt_d = '0;
        if (sense_s != filt_q) begin
            if (gl_cnt_q >= GL_W'(GLITCH_CYCLES - 1)) begin
                filt_d = sense_s;
            end else begin
                gl_cnt_d = gl_cnt_q + GL_W'(1);
            end
        end
    end

    assign req_low = !oe_s && !out_s;
    assign st_inc  = (st_cnt_q == ST_W'(SRST_MIN_CYCLES)) ? st_cnt_q : st_cnt_q + ST_W'(1);
    assign st_done = (st_cnt_q >= ST_W'(SRST_MIN_CYCLES - 1));

    // Drive stretcher FSM; an absent target is never driven
    always_comb begin
        st_d     = st_q;
        st_cnt_d = '0;
        oe_d     = 1'b1;
        out_d    = 1'b1;
        if (!pres_out_q) begin
            st_d = IDLE;
        end else begin
            unique case (st_q)
                IDLE: begin
                    oe_d  = oe_s;
                    out_d = out_s;
                    if (req_low) begin
                        st_d = ASSERT;
                    end
                end
                ASSERT: begin
                    if (!req_low && st_done) begin
                        st_d  = IDLE;
                        oe_d  = oe_s;
                        out_d = out_s;
                    end else begin
                        st_cnt_d = st_inc;
                        oe_d     = 1'b0;
                        out_d    = 1'b0;
                    end
                end
            endcase
        end
    end

    // Sticky reset-seen flag; only falls we are not causing count, and a set beats a clear
    always_comb begin
        event_d = event_q;
        if (EVENT_CLR) begin
            event_d = 1'b0;
        end
        if (filt_q && !filt_d && (st_q == IDLE) && oe_q) begin
            event_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_target_conditioner.sv
// Directed bench for jtag_target_conditioner with hand-derived edge counts at default parameters.
module tb_jtag_target_conditioner;

    logic CLK;
    logic nRST;
    logic TARGET_PRESENT;
    logic nSRST_SENSE;
    logic RTCK;
    logic FT_nSRST_OE;
    logic FT_nSRST_OUT;
    logic EVENT_CLR;
    logic FT_TARGET_PRESENT;
    logic FT_nSRST_IN;
    logic FT_RTCK;
    logic nSRST_OE;
    logic nSRST_OUT;
    logic SRST_EVENT;

    int checks;
    int errors;

    // Results of the last run() window; edge indices count posedges from the window start
    int r_oe_first, r_oe_rel, r_oe_low, r_out_low;
    int r_in_first, r_in_low, r_ev_first, r_ev_cnt, r_pres_fall;

    jtag_target_conditioner dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .TARGET_PRESENT    (TARGET_PRESENT),
        .nSRST_SENSE       (nSRST_SENSE),
        .RTCK              (RTCK),
        .FT_nSRST_OE       (FT_nSRST_OE),
        .FT_nSRST_OUT      (FT_nSRST_OUT),
        .EVENT_CLR         (EVENT_CLR),
        .FT_TARGET_PRESENT (FT_TARGET_PRESENT),
        .FT_nSRST_IN       (FT_nSRST_IN),
        .FT_RTCK           (FT_RTCK),
        .nSRST_OE          (nSRST_OE),
        .nSRST_OUT         (nSRST_OUT),
        .SRST_EVENT        (SRST_EVENT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a request-low run, a sense-low window and an optional EVENT_CLR cycle, recording output timing
    task automatic run(input int req_len, input int s_from, input int s_to, input int clr_at, input int window);
        r_oe_first = -1; r_oe_rel = -1; r_oe_low = 0; r_out_low = 0;
        r_in_first = -1; r_in_low = 0; r_ev_first = -1; r_ev_cnt = 0; r_pres_fall = -1;
        for (int i = 0; i < window; i++) begin
            FT_nSRST_OE  = !(i < req_len);
            FT_nSRST_OUT = !(i < req_len);
            nSRST_SENSE  = !((i >= s_from) && (i < s_to));
            EVENT_CLR    = (i == clr_at);
            tick();
            if (!nSRST_OE) begin
                r_oe_low++;
                if (r_oe_first < 0) r_oe_first = i + 1;
            end else if ((r_oe_first >= 0) && (r_oe_rel < 0)) begin
                r_oe_rel = i + 1;
            end
            if (!nSRST_OUT) r_out_low++;
            if (!FT_nSRST_IN) begin
                r_in_low++;
                if (r_in_first < 0) r_in_first = i + 1;
            end
            if (SRST_EVENT) begin
                r_ev_cnt++;
                if (r_ev_first < 0) r_ev_first = i + 1;
            end
            if (!FT_TARGET_PRESENT && (r_pres_fall < 0)) r_pres_fall = i + 1;
        end
        FT_nSRST_OE  = 1'b1;
        FT_nSRST_OUT = 1'b1;
        nSRST_SENSE  = 1'b1;
        EVENT_CLR    = 1'b0;
    endtask

    task automatic clear_event();
        EVENT_CLR = 1'b1;
        tick();
        EVENT_CLR = 1'b0;
    endtask

    initial begin
        int first;
        checks = 0;
        errors = 0;
        nRST = 1'b0;
        TARGET_PRESENT = 1'b0;
        nSRST_SENSE = 1'b1;
        RTCK = 1'b0;
        FT_nSRST_OE = 1'b1;
        FT_nSRST_OUT = 1'b1;
        EVENT_CLR = 1'b0;

        // Reset values
        #23;
        check("rst_present", FT_TARGET_PRESENT, 0);
        check("rst_srst_in", FT_nSRST_IN, 1);
        check("rst_rtck", FT_RTCK, 0);
        check("rst_oe", nSRST_OE, 1);
        check("rst_out", nSRST_OUT, 1);
        check("rst_event", SRST_EVENT, 0);
        nRST = 1'b1;
        tick();

        // RTCK: pure synchroniser delay
        RTCK = 1'b1;
        tick();
        check("rtck_lat1", FT_RTCK, 0);
        tick();
        check("rtck_lat2", FT_RTCK, 1);
        RTCK = 1'b0;

        // Presence rise: 2 + 1024 edges
        TARGET_PRESENT = 1'b1;
        repeat (1025) tick();
        check("pres_rise_1025", FT_TARGET_PRESENT, 0);
        tick();
        check("pres_rise_1026", FT_TARGET_PRESENT, 1);

        // Reset mid-PRESENT, then a one-cycle glitch at cycle 500 restarts qualification
        #3 nRST = 1'b0;
        TARGET_PRESENT = 1'b0;
        #2;
        check("rst_async_pres", FT_TARGET_PRESENT, 0);
        nRST = 1'b1;
        tick();
        TARGET_PRESENT = 1'b1;
        repeat (500) tick();
        TARGET_PRESENT = 1'b0;
        tick();
        TARGET_PRESENT = 1'b1;
        repeat (1025) tick();
        check("glitch_rise_1526", FT_TARGET_PRESENT, 0);
        tick();
        check("glitch_rise_1527", FT_TARGET_PRESENT, 1);

        // Short 3-cycle request stretched to 256 cycles
        run(3, 0, 0, -1, 600);
        check("str3_first", r_oe_first, 3);
        check("str3_oe_low", r_oe_low, 256);
        check("str3_out_low", r_out_low, 256);
        check("str3_release", r_oe_rel, 259);
        check("str3_event", r_ev_cnt, 0);

        // IDLE passthrough of a drive-high request
        FT_nSRST_OE = 1'b0;
        FT_nSRST_OUT = 1'b1;
        repeat (2) tick();
        check("pass_oe_lat2", nSRST_OE, 1);
        tick();
        check("pass_oe_lat3", nSRST_OE, 0);
        check("pass_out_lat3", nSRST_OUT, 1);
        FT_nSRST_OE = 1'b1;
        repeat (3) tick();
        check("pass_oe_back", nSRST_OE, 1);

        // Long request longer than the minimum
        run(400, 0, 0, -1, 800);
        check("str400_first", r_oe_first, 3);
        check("str400_oe_low", r_oe_low, 400);
        check("str400_release", r_oe_rel, 403);

        // Sense filter: 3-cycle pulse rejected, 4-cycle pulse passes and flags an event
        run(0, 0, 3, -1, 20);
        check("glitch3_in_low", r_in_low, 0);
        check("glitch3_event", r_ev_cnt, 0);
        run(0, 0, 4, -1, 30);
        check("glitch4_in_first", r_in_first, 6);
        check("glitch4_in_low", r_in_low, 4);
        check("glitch4_ev_first", r_ev_first, 6);
        check("glitch4_ev_sticky", r_ev_cnt, 25);
        clear_event();
        check("ev_clear", SRST_EVENT, 0);

        // EVENT_CLR on the same edge as a new fall: set wins
        run(0, 0, 4, 5, 30);
        check("setclr_ev_first", r_ev_first, 6);
        check("setclr_ev_cnt", r_ev_cnt, 25);
        clear_event();
        check("ev_clear2", SRST_EVENT, 0);

        // Our own drive pulls the sense low: filtered but no event
        run(3, 4, 200, -1, 300);
        check("own_oe_low", r_oe_low, 256);
        check("own_in_first", r_in_first, 10);
        check("own_in_low", r_in_low, 196);
        check("own_event", r_ev_cnt, 0);

        // Presence fall, then requests into an absent target are ignored
        TARGET_PRESENT = 1'b0;
        repeat (1025) tick();
        check("pres_fall_1025", FT_TARGET_PRESENT, 1);
        tick();
        check("pres_fall_1026", FT_TARGET_PRESENT, 0);
        run(50, 0, 0, -1, 60);
        check("absent_oe_low", r_oe_low, 0);
        check("absent_out_low", r_out_low, 0);

        // Debounced presence loss 100 cycles into ASSERT aborts on the next edge
        TARGET_PRESENT = 1'b1;
        repeat (1026) tick();
        check("pres_again", FT_TARGET_PRESENT, 1);
        TARGET_PRESENT = 1'b0;
        repeat (923) tick();
        run(300, 0, 0, -1, 200);
        check("abort_pres_fall", r_pres_fall, 103);
        check("abort_oe_first", r_oe_first, 3);
        check("abort_release", r_oe_rel, 104);
        check("abort_oe_low", r_oe_low, 101);

        // nRST mid-ASSERT releases the pad asynchronously
        TARGET_PRESENT = 1'b1;
        repeat (1030) tick();
        FT_nSRST_OE = 1'b0;
        FT_nSRST_OUT = 1'b0;
        repeat (50) tick();
        check("midassert_oe", nSRST_OE, 0);
        #3 nRST = 1'b0;
        #2;
        check("rst_assert_oe", nSRST_OE, 1);
        check("rst_assert_out", nSRST_OUT, 1);
        check("rst_assert_pres", FT_TARGET_PRESENT, 0);
        check("rst_assert_event", SRST_EVENT, 0);
        FT_nSRST_OE = 1'b1;
        FT_nSRST_OUT = 1'b1;
        nRST = 1'b1;

        // nRST mid-QUAL_IN: qualification restarts from zero after release
        repeat (300) tick();
        check("midqual_pres", FT_TARGET_PRESENT, 0);
        #3 nRST = 1'b0;
        #2;
        check("rst_qual_pres", FT_TARGET_PRESENT, 0);
        nRST = 1'b1;
        first = -1;
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (FT_TARGET_PRESENT && (first < 0)) first = i;
        end
        check("requal_rise", first, 1026);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
